// File: rtl/riscv_core_startup_resp.sv
// Startup handshake responder: clears the register file, fills the pipeline stage enables, then raises core_ready.
// Optional post-fill hold-off state enabled by defining RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN.
module riscv_core_startup_resp #(
    parameter int REG_COUNT  = 32,
    parameter int ADDR_W     = 5,
    parameter int STAGES     = 5,
    parameter int BOOT_DELAY = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              reset_ACT,
    input  logic              main_ACT,
    output logic              rf_clr_we,
    output logic [ADDR_W-1:0] rf_clr_addr,
    output logic [STAGES-1:0] stage_en,
    output logic              core_ready,
    output logic              seq_err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_MAIN,
        FILL,
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
        DELAY,
`endif
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);
    localparam logic [STAGES-1:0] ALL_ON    = '1;
    localparam logic [STAGES-1:0] FIRST_ON  = STAGES'(1);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STAGES-1:0] stage_q, stage_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
    localparam int DLY_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(BOOT_DELAY - 1);
    logic [DLY_W-1:0] dly_q, dly_d;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = '0;
        stage_d = stage_q;
        ready_d = ready_q;
        err_d   = err_q;
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
        dly_d   = dly_q;
`endif
        case (state_q)
            IDLE: begin
                stage_d = '0;
                ready_d = 1'b0;
                if (main_ACT && !reset_ACT) begin
                    err_d = 1'b1;
                end
            end
            CLEAR: begin
                // The address register doubles as the clear counter.
                if (addr_q == LAST_ADDR) begin
                    state_d = main_ACT ? FILL : WAIT_MAIN;
                    stage_d = main_ACT ? FIRST_ON : '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            WAIT_MAIN: begin
                if (main_ACT) begin
                    state_d = FILL;
                    stage_d = FIRST_ON;
                end
            end
            FILL: begin
                if (!main_ACT) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (stage_q == ALL_ON) begin
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
                    state_d = DELAY;
                    dly_d   = '0;
`else
                    state_d = RUN;
                    ready_d = 1'b1;
`endif
                end else begin
                    stage_d = (stage_q << 1) | FIRST_ON;
                end
            end
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
            DELAY: begin
                if (!main_ACT) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
`endif
            RUN: begin
                if (!main_ACT) begin
                    state_d = IDLE;
                    stage_d = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
                ready_d = 1'b0;
            end
        endcase

        // A reset activation restarts the clear from any state and outranks main_ACT.
        if (reset_ACT) begin
            state_d = CLEAR;
            we_d    = 1'b1;
            addr_d  = '0;
            stage_d = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef RISCV_CORE_STARTUP_RESP_BOOT_DELAY_EN
            dly_q   <= dly_d;
`endif
        end
    end

    assign rf_clr_we   = we_q;
    assign rf_clr_addr = addr_q;
    assign stage_en    = stage_q;
    assign core_ready  = ready_q;
    assign seq_err     = err_q;

endmodule
